// File: rtl/team_03_wb_master_if.sv
// Wishbone classic signal bundle between the team_03 initiator and the arbiter.
interface team_03_wb_master_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/team_03_wb_master.sv
// Single-transfer Wishbone classic initiator: one valid/ready request becomes one
// bus cycle, answered by a one-cycle response pulse carrying read data or a timeout.
module team_03_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_adr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_sel,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [31:0]          rsp_rdata,
  output logic                 busy,
  team_03_wb_master_if.master  wb
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  // Gated with nrst so req_ready stays low while reset is asserted.
  assign req_ready   = (state == IDLE) && nrst;
  assign busy        = (state == BUS);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      wb.ADR_O  <= '0;
      wb.DAT_O  <= '0;
      wb.SEL_O  <= '0;
      wb.WE_O   <= 1'b0;
      wb.STB_O  <= 1'b0;
      wb.CYC_O  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wb.ADR_O <= req_adr;
            wb.DAT_O <= req_wdata;
            wb.SEL_O <= req_sel;
            wb.WE_O  <= req_we;
            wb.STB_O <= 1'b1;
            wb.CYC_O <= 1'b1;
            cnt      <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // ACK is tested first so it wins over a simultaneous timeout.
          if (wb.ACK_I) begin
            wb.WE_O   <= 1'b0;
            wb.STB_O  <= 1'b0;
            wb.CYC_O  <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= wb.WE_O ? '0 : wb.DAT_I;
          end else if (timeout_hit) begin
            wb.WE_O   <= 1'b0;
            wb.STB_O  <= 1'b0;
            wb.CYC_O  <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_team_03_wb_master.sv
// Directed bench for team_03_wb_master: read, write, timeout, ACK-at-limit,
// back-to-back, idle ACKs and reset during a bus cycle.
module tb_team_03_wb_master;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_count = 0;

  logic [31:0] b2b_adr [3];
  logic [31:0] b2b_dat [3];

  always #5 clk = ~clk;

  team_03_wb_master_if wb ();

  team_03_wb_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .wb        (wb.master)
  );

  always @(posedge clk) begin
    #1;
    if (rsp_valid === 1'b1) rsp_count++;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_wdata = '0;
    req_sel   = '0;
    wb.ACK_I  = 1'b0;
    wb.DAT_I  = '0;
    b2b_adr[0] = 32'h3000_0100; b2b_dat[0] = 32'h1111_0001;
    b2b_adr[1] = 32'h3000_0104; b2b_dat[1] = 32'h2222_0002;
    b2b_adr[2] = 32'h3000_0108; b2b_dat[2] = 32'h3333_0003;

    // reset state
    repeat (2) @(negedge clk);
    chk1("rst_cyc", wb.CYC_O, 1'b0);
    chk1("rst_stb", wb.STB_O, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_ready_low", req_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_adr", wb.ADR_O, 32'h0);
    nrst = 1'b1;
    #1 chk1("rst_ready_high", req_ready, 1'b1);

    // read, ACK two cycles after STB rises
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0010; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("rd_cyc", wb.CYC_O, 1'b1);
    chk1("rd_stb", wb.STB_O, 1'b1);
    chk1("rd_we", wb.WE_O, 1'b0);
    chk1("rd_busy", busy, 1'b1);
    chk1("rd_ready", req_ready, 1'b0);
    chk32("rd_adr", wb.ADR_O, 32'h3000_0010);
    @(negedge clk);
    chk1("rd_no_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    chk1("rd_stb_wait", wb.STB_O, 1'b1);
    wb.ACK_I = 1'b1; wb.DAT_I = 32'hDEAD_BEEF;
    @(negedge clk);
    wb.ACK_I = 1'b0; wb.DAT_I = '0;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk32("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk1("rd_err", rsp_err, 1'b0);
    chk1("rd_cyc_drop", wb.CYC_O, 1'b0);
    chk1("rd_ready_back", req_ready, 1'b1);
    @(negedge clk);
    chk1("rd_pulse_end", rsp_valid, 1'b0);
    chk32("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
    chk32("rd_count", rsp_count, 32'd1);

    // timeout: no ACK, CYC high exactly 8 cycles
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("to_cyc_high", wb.CYC_O, 1'b1);
      chk1("to_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    chk1("to_cyc_drop", wb.CYC_O, 1'b0);
    chk1("to_stb_drop", wb.STB_O, 1'b0);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_err", rsp_err, 1'b1);
    chk32("to_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    chk1("to_pulse_end", rsp_valid, 1'b0);
    chk1("to_err_hold", rsp_err, 1'b1);

    // write, zero-wait ACK; changed req_* during BUS must be ignored
    wb.DAT_I = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0004;
    req_wdata = 32'h1234_5678; req_sel = 4'b0011;
    @(negedge clk);
    req_valid = 1'b0; req_adr = 32'h0BAD_0BAD; req_wdata = 32'h0; req_sel = 4'hF;
    chk1("wr_stb", wb.STB_O, 1'b1);
    chk1("wr_we", wb.WE_O, 1'b1);
    chk32("wr_adr", wb.ADR_O, 32'h3000_0004);
    chk32("wr_dat", wb.DAT_O, 32'h1234_5678);
    chk32("wr_sel", {28'h0, wb.SEL_O}, 32'h3);
    wb.ACK_I = 1'b1;
    @(negedge clk);
    wb.ACK_I = 1'b0; wb.DAT_I = '0;
    chk1("wr_rsp_valid", rsp_valid, 1'b1);
    chk32("wr_rdata", rsp_rdata, 32'h0);
    chk1("wr_err", rsp_err, 1'b0);
    chk1("wr_we_drop", wb.WE_O, 1'b0);
    chk1("wr_cyc_drop", wb.CYC_O, 1'b0);
    chk32("wr_adr_hold", wb.ADR_O, 32'h3000_0004);
    chk32("wr_dat_hold", wb.DAT_O, 32'h1234_5678);

    // ACK arriving in the 8th BUS cycle beats the timeout
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0030;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk1("ack8_cyc_high", wb.CYC_O, 1'b1);
      @(negedge clk);
    end
    chk1("ack8_cyc_8th", wb.CYC_O, 1'b1);
    wb.ACK_I = 1'b1; wb.DAT_I = 32'hA5A5_5A5A;
    @(negedge clk);
    wb.ACK_I = 1'b0; wb.DAT_I = '0;
    chk1("ack8_rsp_valid", rsp_valid, 1'b1);
    chk1("ack8_err", rsp_err, 1'b0);
    chk32("ack8_rdata", rsp_rdata, 32'hA5A5_5A5A);

    // back-to-back reads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = b2b_adr[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("b2b_cyc_high", wb.CYC_O, 1'b1);
      chk32("b2b_adr", wb.ADR_O, b2b_adr[k]);
      wb.ACK_I = 1'b1; wb.DAT_I = b2b_dat[k];
      if (k < 2) req_adr = b2b_adr[k+1];
      else req_valid = 1'b0;
      @(negedge clk);
      wb.ACK_I = 1'b0; wb.DAT_I = '0;
      chk1("b2b_cyc_gap", wb.CYC_O, 1'b0);
      chk1("b2b_rsp_valid", rsp_valid, 1'b1);
      chk32("b2b_rdata", rsp_rdata, b2b_dat[k]);
    end
    @(negedge clk);
    chk1("b2b_idle_cyc", wb.CYC_O, 1'b0);
    chk1("b2b_idle_rsp", rsp_valid, 1'b0);
    chk32("b2b_count", rsp_count, 32'd7);

    // ACK pulses while idle
    for (int i = 0; i < 3; i++) begin
      wb.ACK_I = 1'b1; wb.DAT_I = 32'hCAFE_0000;
      @(negedge clk);
      chk1("idle_ack_rsp", rsp_valid, 1'b0);
      chk1("idle_ack_busy", busy, 1'b0);
      chk1("idle_ack_ready", req_ready, 1'b1);
      wb.ACK_I = 1'b0;
      @(negedge clk);
    end
    chk32("idle_ack_count", rsp_count, 32'd7);

    // reset in the middle of a bus cycle
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("mid_cyc_before", wb.CYC_O, 1'b1);
    #2 nrst = 1'b0;
    #1;
    chk1("mid_cyc_async", wb.CYC_O, 1'b0);
    chk1("mid_stb_async", wb.STB_O, 1'b0);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_ready_low", req_ready, 1'b0);
    chk32("mid_rdata_clr", rsp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("post_rst_ready", req_ready, 1'b1);
      chk1("post_rst_rsp", rsp_valid, 1'b0);
      chk1("post_rst_cyc", wb.CYC_O, 1'b0);
    end
    chk32("post_rst_count", rsp_count, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
